reg_file_param: RTL

//   Parametrised multi-read, single-write register file with clocked writes and asynchronous

---
 rtl/reg_file_pkg.sv | 12 +
 rtl/reg_file_if.sv | 25 ++
 rtl/reg_file_init_fsm.sv | 39 +++
 rtl/reg_file_param.sv | 57 +++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared FSM state codes, depth derivation and the re-init pattern.
package reg_file_pkg;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction
    function automatic int init_val(input int idx, input int depth);
        return (idx + 1) % depth;
    endfunction
endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: read ports, write port and re-init handshake of the register file.
interface reg_file_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [DATA_W-1:0]        wr_data_out;
    logic                     wr_drop;
    logic                     init_req;
    logic                     init_busy;
    logic                     init_done;
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, init_req,
        input  rd_data, wr_data_out, wr_drop, init_busy, init_done
    );
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, init_req,
        output rd_data, wr_data_out, wr_drop, init_busy, init_done
    );
endinterface

// File: rtl/reg_file_init_fsm.sv
// reg_file_init_fsm: IDLE/SWEEP/DONE sequencer that rewrites every entry with its init value.
module reg_file_init_fsm
    import reg_file_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_init_req,
    input  logic              i_wr_en,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_wr_drop,
    output logic              o_sweep_we,
    output logic [ADDR_W-1:0] o_sweep_addr,
    output logic [DATA_W-1:0] o_sweep_data
);
    localparam int DEPTH = depth_of(ADDR_W);
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    // ptr is all-ones on the last sweep cycle and wraps back to zero by itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= (r_state == S_IDLE)  ? (i_init_req ? S_SWEEP : S_IDLE) :
                       (r_state == S_SWEEP) ? (&r_ptr ? S_DONE : S_SWEEP) : S_IDLE;
            r_ptr   <= (r_state == S_SWEEP) ? r_ptr + ADDR_W'(1) : '0;
        end
    end
    assign o_busy       = r_state == S_SWEEP;
    assign o_done       = r_state == S_DONE;
    assign o_wr_drop    = i_wr_en & o_busy;
    assign o_sweep_we   = o_busy;
    assign o_sweep_addr = r_ptr;
    assign o_sweep_data = DATA_W'(init_val(int'(r_ptr), DEPTH));
endmodule

// File: rtl/reg_file_param.sv
// reg_file_param: multi-read single-write register file with hardware re-init sweep.
// Define REG_FILE_BYPASS_EN for write-first forwarding of accepted writes to the read ports.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
) (
    input logic     clk,
    input logic     rst_n,
    reg_file_if.slave bus
);
    localparam int DEPTH = depth_of(ADDR_W);
    logic [DATA_W-1:0]        r_mem [DEPTH];
    logic                     w_busy;
    logic                     w_sweep_we;
    logic                     w_wr_acc;
    logic [ADDR_W-1:0]        w_sweep_addr;
    logic [DATA_W-1:0]        w_sweep_data;
    logic [NUM_RD*DATA_W-1:0] w_rd_data;
    reg_file_init_fsm #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_init_req   (bus.init_req),
        .i_wr_en      (bus.wr_en),
        .o_busy       (w_busy),
        .o_done       (bus.init_done),
        .o_wr_drop    (bus.wr_drop),
        .o_sweep_we   (w_sweep_we),
        .o_sweep_addr (w_sweep_addr),
        .o_sweep_data (w_sweep_data)
    );
    assign bus.init_busy = w_busy;
    assign w_wr_acc      = bus.wr_en & ~w_busy;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= DATA_W'(init_val(i, DEPTH));
        else if (w_sweep_we)
            r_mem[w_sweep_addr] <= w_sweep_data;
        else if (w_wr_acc)
            r_mem[bus.wr_addr] <= bus.wr_data;
    end
    function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
`ifdef REG_FILE_BYPASS_EN
        return (w_wr_acc && a == bus.wr_addr) ? bus.wr_data : r_mem[a];
`else
        return r_mem[a];
`endif
    endfunction
    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) w_rd_data[k*DATA_W +: DATA_W] = rd_word(bus.rd_addr[k*ADDR_W +: ADDR_W]);
    end
    assign bus.rd_data     = w_rd_data;
    assign bus.wr_data_out = rd_word(bus.wr_addr);
endmodule
